// File: rtl/uc_dispara_tiro_if.sv
// Shot-memory write port shared by the spawn controller (master) and the shot memory (slave).
// The memory answers loaded_tiro combinationally for the slot currently addressed.
interface uc_dispara_tiro_if #(
  parameter int ADDR_W  = 2,
  parameter int COORD_W = 8
);
  logic [ADDR_W-1:0]  endereco_tiro;
  logic               enable_mem_tiro;
  logic               new_loaded;
  logic [COORD_W-1:0] new_x;
  logic [COORD_W-1:0] new_y;
  logic [1:0]         new_opcode;
  logic               loaded_tiro;

  modport master (
    output endereco_tiro,
    output enable_mem_tiro,
    output new_loaded,
    output new_x,
    output new_y,
    output new_opcode,
    input  loaded_tiro
  );

  modport slave (
    input  endereco_tiro,
    input  enable_mem_tiro,
    input  new_loaded,
    input  new_x,
    input  new_y,
    input  new_opcode,
    output loaded_tiro
  );
endinterface

// File: rtl/uc_dispara_tiro.sv
// Shot-spawn controller: on a fire request, finds the first free shot slot and writes the
// ship position (offset DESLOC along the ship direction) into it, rate-limited by a cooldown.
module uc_dispara_tiro #(
  parameter int N_TIROS  = 4,
  parameter int ADDR_W   = 2,
  parameter int COORD_W  = 8,
  parameter int DESLOC   = 1,
  parameter int COOLDOWN = 16,
  parameter int CD_W     = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               disparar,
  input  logic               move_ativo,
  input  logic [COORD_W-1:0] nave_x,
  input  logic [COORD_W-1:0] nave_y,
  input  logic [1:0]         nave_direcao,
  uc_dispara_tiro_if.master  mem,
  output logic               pronto,
  output logic               disparo_concluido,
  output logic               sem_slot,
  output logic [4:0]         db_estado_dispara
);

  typedef enum logic [3:0] {
    INICIO        = 4'd0,
    ESPERA        = 4'd1,
    CAPTURA       = 4'd2,
    VERIFICA_SLOT = 4'd3,
    PROXIMO       = 4'd4,
    GRAVA         = 4'd5,
    SINALIZA      = 4'd6,
    SEM_SLOT      = 4'd7,
    ESPERA_SOLTAR = 4'd8
  } estado_t;

  localparam logic [COORD_W:0]  DESLOC_EXT  = (COORD_W+1)'(DESLOC);
  localparam logic [ADDR_W-1:0] ULTIMO_SLOT = ADDR_W'(N_TIROS - 1);
  localparam logic [CD_W-1:0]   CD_RECARGA  = CD_W'(COOLDOWN);

  estado_t            estado_reg, estado_next;
  logic [ADDR_W-1:0]  indice_reg, indice_next;
  logic [CD_W-1:0]    cooldown_reg, cooldown_next;
  logic [COORD_W-1:0] x_reg, x_next;
  logic [COORD_W-1:0] y_reg, y_next;
  logic [1:0]         dir_reg, dir_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_reg   <= INICIO;
      indice_reg   <= '0;
      cooldown_reg <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      dir_reg      <= '0;
    end else begin
      estado_reg   <= estado_next;
      indice_reg   <= indice_next;
      cooldown_reg <= cooldown_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      dir_reg      <= dir_next;
    end
  end

  // Index returns to 0 whenever a scan ends so the address bus idles at slot 0.
  always_comb begin
    estado_next   = estado_reg;
    indice_next   = indice_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    dir_next      = dir_reg;
    cooldown_next = (cooldown_reg != '0) ? cooldown_reg - 1'b1 : cooldown_reg;

    case (estado_reg)
      INICIO: begin
        indice_next = '0;
        estado_next = ESPERA;
      end
      ESPERA: begin
        indice_next = '0;
        if (disparar && !move_ativo && (cooldown_reg == '0))
          estado_next = CAPTURA;
      end
      CAPTURA: begin
        x_next      = nave_x;
        y_next      = nave_y;
        dir_next    = nave_direcao;
        indice_next = '0;
        estado_next = VERIFICA_SLOT;
      end
      VERIFICA_SLOT: begin
        if (!mem.loaded_tiro) begin
          estado_next = GRAVA;
        end else if (indice_reg == ULTIMO_SLOT) begin
          indice_next = '0;
          estado_next = SEM_SLOT;
        end else begin
          estado_next = PROXIMO;
        end
      end
      PROXIMO: begin
        indice_next = indice_reg + 1'b1;
        estado_next = VERIFICA_SLOT;
      end
      GRAVA: begin
        indice_next = '0;
        estado_next = SINALIZA;
      end
      SINALIZA: begin
        cooldown_next = CD_RECARGA;
        estado_next   = ESPERA_SOLTAR;
      end
      SEM_SLOT: begin
        estado_next = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        if (!disparar)
          estado_next = ESPERA;
      end
      default: begin
        indice_next = '0;
        estado_next = INICIO;
      end
    endcase
  end

  // Saturating +/- DESLOC for each axis; index 0 is X, index 1 is Y.
  logic [COORD_W-1:0] eixo  [2];
  logic [COORD_W-1:0] mais  [2];
  logic [COORD_W-1:0] menos [2];

  assign eixo[0] = x_reg;
  assign eixo[1] = y_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_eixo
      logic [COORD_W:0] soma;
      assign soma      = {1'b0, eixo[gi]} + DESLOC_EXT;
      assign mais[gi]  = soma[COORD_W] ? {COORD_W{1'b1}} : soma[COORD_W-1:0];
      assign menos[gi] = ({1'b0, eixo[gi]} < DESLOC_EXT) ? '0
                         : eixo[gi] - DESLOC_EXT[COORD_W-1:0];
    end
  endgenerate

  always_comb begin
    pronto              = 1'b0;
    disparo_concluido   = 1'b0;
    sem_slot            = 1'b0;
    mem.endereco_tiro   = indice_reg;
    mem.enable_mem_tiro = 1'b0;
    mem.new_loaded      = 1'b0;
    mem.new_x           = '0;
    mem.new_y           = '0;
    mem.new_opcode      = '0;
    db_estado_dispara   = {1'b0, estado_reg};

    case (estado_reg)
      ESPERA:   pronto = (cooldown_reg == '0);
      GRAVA: begin
        mem.enable_mem_tiro = 1'b1;
        mem.new_loaded      = 1'b1;
        mem.new_opcode      = dir_reg;
        // dir[1] selects the axis (0 = X, 1 = Y), dir[0] the sign (1 = minus).
        if (!dir_reg[1]) begin
          mem.new_x = dir_reg[0] ? menos[0] : mais[0];
          mem.new_y = y_reg;
        end else begin
          mem.new_x = x_reg;
          mem.new_y = dir_reg[0] ? menos[1] : mais[1];
        end
      end
      SINALIZA: disparo_concluido = 1'b1;
      SEM_SLOT: sem_slot = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uc_dispara_tiro.sv
// Bench for uc_dispara_tiro: a behavioural shot memory plus a reference model of slot
// selection, spawn arithmetic and scan timing derived from the state sequence rules.
module tb_uc_dispara_tiro;
  localparam int N_TIROS  = 4;
  localparam int ADDR_W   = 2;
  localparam int COORD_W  = 8;
  localparam int DESLOC   = 1;
  localparam int COOLDOWN = 16;
  localparam int CD_W     = 5;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               disparar = 1'b0;
  logic               move_ativo = 1'b0;
  logic [COORD_W-1:0] nave_x = '0;
  logic [COORD_W-1:0] nave_y = '0;
  logic [1:0]         nave_direcao = '0;
  logic               pronto, disparo_concluido, sem_slot;
  logic [4:0]         db_estado_dispara;

  always #5 clock = ~clock;

  uc_dispara_tiro_if #(.ADDR_W(ADDR_W), .COORD_W(COORD_W)) mem_if ();

  uc_dispara_tiro #(
    .N_TIROS(N_TIROS), .ADDR_W(ADDR_W), .COORD_W(COORD_W),
    .DESLOC(DESLOC), .COOLDOWN(COOLDOWN), .CD_W(CD_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .disparar(disparar),
    .move_ativo(move_ativo),
    .nave_x(nave_x),
    .nave_y(nave_y),
    .nave_direcao(nave_direcao),
    .mem(mem_if),
    .pronto(pronto),
    .disparo_concluido(disparo_concluido),
    .sem_slot(sem_slot),
    .db_estado_dispara(db_estado_dispara)
  );

  // Shot memory: loaded bits only; the bench preloads it through mem_set_*.
  logic [N_TIROS-1:0] slot_mem = '0;
  logic [N_TIROS-1:0] mem_set_val = '0;
  logic               mem_set_req = 1'b0;
  int                 write_count = 0;

  assign mem_if.loaded_tiro = slot_mem[mem_if.endereco_tiro];

  always @(posedge clock) begin
    if (mem_set_req) begin
      slot_mem <= mem_set_val;
    end else if (mem_if.enable_mem_tiro) begin
      slot_mem[mem_if.endereco_tiro] <= mem_if.new_loaded;
      write_count <= write_count + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  function automatic int first_free(input logic [N_TIROS-1:0] m);
    for (int i = 0; i < N_TIROS; i++)
      if (!m[i]) return i;
    return -1;
  endfunction

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > (1 << COORD_W) - 1) return (1 << COORD_W) - 1;
    return v;
  endfunction

  function automatic void spawn(input int x, input int y, input int d, output int ex, output int ey);
    ex = x;
    ey = y;
    case (d)
      0: ex = sat(x + DESLOC);
      1: ex = sat(x - DESLOC);
      2: ey = sat(y + DESLOC);
      default: ey = sat(y - DESLOC);
    endcase
  endfunction

  // Request seen in ESPERA, one cycle to capture, then a check per slot with a step
  // between slots: the write of slot k lands 3 + 2k cycles after the request.
  function automatic int write_latency(input int k);
    return 3 + 2 * k;
  endfunction

  // ---------------- observation of one shot ----------------
  int obs_writes, obs_wcnt, obs_addr, obs_x, obs_y, obs_op, obs_loaded;
  int obs_done_cnt, obs_done_pulses, obs_sem_cnt, obs_sem_pulses;
  int obs_prox, obs_pronto_cnt;
  bit obs_leak;

  task automatic load_mem(input logic [N_TIROS-1:0] v);
    mem_set_val = v;
    mem_set_req = 1'b1;
    @(negedge clock);
    mem_set_req = 1'b0;
  endtask

  task automatic wait_pronto(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (pronto) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Presses fire for one attempt and records what happens over a fixed 32-cycle window.
  task automatic run_shot;
    int end_cnt;
    end_cnt = -1;
    obs_writes = 0; obs_wcnt = -1; obs_addr = -1; obs_x = -1; obs_y = -1; obs_op = -1;
    obs_loaded = -1; obs_done_cnt = -1; obs_done_pulses = 0; obs_sem_cnt = -1;
    obs_sem_pulses = 0; obs_prox = 0; obs_pronto_cnt = -1; obs_leak = 1'b0;
    disparar = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clock);
      if (db_estado_dispara == 5'd4) obs_prox++;
      if (mem_if.enable_mem_tiro) begin
        obs_writes++;
        obs_wcnt = i;
        obs_addr = int'(mem_if.endereco_tiro);
        obs_x = int'(mem_if.new_x);
        obs_y = int'(mem_if.new_y);
        obs_op = int'(mem_if.new_opcode);
        obs_loaded = int'(mem_if.new_loaded);
      end else if (mem_if.new_loaded || mem_if.new_x != 0 || mem_if.new_y != 0 || mem_if.new_opcode != 0) begin
        obs_leak = 1'b1;
      end
      if ((db_estado_dispara == 5'd1 || db_estado_dispara >= 5'd6) && mem_if.endereco_tiro != 0)
        obs_leak = 1'b1;
      if (disparo_concluido) begin
        obs_done_pulses++;
        if (obs_done_cnt < 0) obs_done_cnt = i;
      end
      if (sem_slot) begin
        obs_sem_pulses++;
        if (obs_sem_cnt < 0) obs_sem_cnt = i;
      end
      if (end_cnt >= 0 && pronto && obs_pronto_cnt < 0) obs_pronto_cnt = i - end_cnt;
      if (end_cnt < 0 && (disparo_concluido || sem_slot)) begin
        end_cnt = i;
        disparar = 1'b0;
      end
    end
    disparar = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (db_estado_dispara !== 5'd0) begin
      failures++; $display("FAIL reset_state: got %0d expected 0", db_estado_dispara);
    end
    checks++;
    if ({pronto, disparo_concluido, sem_slot, mem_if.enable_mem_tiro, mem_if.new_loaded} !== 5'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 00000",
        {pronto, disparo_concluido, sem_slot, mem_if.enable_mem_tiro, mem_if.new_loaded});
    end
    checks++;
    if ({mem_if.endereco_tiro, mem_if.new_x, mem_if.new_y, mem_if.new_opcode} !== '0) begin
      failures++; $display("FAIL reset_bus: got addr=%0d x=%0d y=%0d op=%0d expected all 0",
        mem_if.endereco_tiro, mem_if.new_x, mem_if.new_y, mem_if.new_opcode);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (db_estado_dispara !== 5'd1 || pronto !== 1'b1) begin
      failures++; $display("FAIL reset_release: got state=%0d pronto=%b expected state=1 pronto=1",
        db_estado_dispara, pronto);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_shot;
    bit ok;
    int ex, ey;
    load_mem('0);
    nave_x = 8'd10; nave_y = 8'd20; nave_direcao = 2'b00;
    spawn(10, 20, 0, ex, ey);
    wait_pronto(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_pronto: got 0 expected 1"); end
    run_shot();
    checks++;
    if (obs_writes !== 1 || obs_addr !== 0 || obs_loaded !== 1) begin
      failures++; $display("FAIL basic_write: got writes=%0d addr=%0d loaded=%0d expected 1/0/1",
        obs_writes, obs_addr, obs_loaded);
    end
    checks++;
    if (obs_x !== ex || obs_y !== ey || obs_op !== 0) begin
      failures++; $display("FAIL basic_coords: got x=%0d y=%0d op=%0d expected x=%0d y=%0d op=0",
        obs_x, obs_y, obs_op, ex, ey);
    end
    checks++;
    if (obs_wcnt !== write_latency(0) || obs_done_cnt !== obs_wcnt + 1 || obs_done_pulses !== 1) begin
      failures++; $display("FAIL basic_timing: got write@%0d done@%0d pulses=%0d expected write@%0d done@%0d pulses=1",
        obs_wcnt, obs_done_cnt, obs_done_pulses, write_latency(0), write_latency(0) + 1);
    end
    checks++;
    if (obs_pronto_cnt !== COOLDOWN + 1) begin
      failures++; $display("FAIL basic_cooldown: got pronto after %0d cycles expected %0d",
        obs_pronto_cnt, COOLDOWN + 1);
    end
    checks++;
    if (obs_leak !== 1'b0) begin
      failures++; $display("FAIL basic_idle_bus: got leak=1 expected 0");
    end
    $display("test_basic_shot addr=%0d x=%0d y=%0d", obs_addr, obs_x, obs_y);
  endtask

  task automatic test_scan_clamp;
    bit ok;
    load_mem(4'b0011);
    nave_x = 8'd50; nave_y = 8'd0; nave_direcao = 2'b11;
    wait_pronto(ok);
    run_shot();
    checks++;
    if (obs_writes !== 1 || obs_addr !== 2 || obs_x !== 50 || obs_y !== 0 || obs_op !== 3) begin
      failures++; $display("FAIL scan_write: got n=%0d addr=%0d x=%0d y=%0d op=%0d expected 1/2/50/0/3",
        obs_writes, obs_addr, obs_x, obs_y, obs_op);
    end
    checks++;
    if (obs_prox !== 2 || obs_wcnt !== write_latency(2)) begin
      failures++; $display("FAIL scan_steps: got proximo=%0d write@%0d expected 2 and %0d",
        obs_prox, obs_wcnt, write_latency(2));
    end
    $display("test_scan_clamp addr=%0d y=%0d", obs_addr, obs_y);
  endtask

  task automatic test_all_busy;
    bit ok;
    load_mem(4'b1111);
    wait_pronto(ok);
    run_shot();
    checks++;
    if (obs_writes !== 0 || obs_sem_pulses !== 1 || obs_done_pulses !== 0) begin
      failures++; $display("FAIL busy_result: got writes=%0d sem=%0d done=%0d expected 0/1/0",
        obs_writes, obs_sem_pulses, obs_done_pulses);
    end
    checks++;
    if (obs_sem_cnt !== 2 * N_TIROS + 1 || obs_prox !== N_TIROS - 1) begin
      failures++; $display("FAIL busy_timing: got sem@%0d proximo=%0d expected sem@%0d proximo=%0d",
        obs_sem_cnt, obs_prox, 2 * N_TIROS + 1, N_TIROS - 1);
    end
    checks++;
    if (obs_pronto_cnt !== 2) begin
      failures++; $display("FAIL busy_pronto: got pronto after %0d expected 2", obs_pronto_cnt);
    end
    $display("test_all_busy sem@%0d", obs_sem_cnt);
  endtask

  task automatic test_hold_cooldown;
    bit ok;
    int w0, k;
    load_mem('0);
    wait_pronto(ok);
    w0 = write_count;
    disparar = 1'b1;
    repeat (100) @(negedge clock);
    checks++;
    if (write_count - w0 !== 1 || db_estado_dispara !== 5'd8) begin
      failures++; $display("FAIL hold_one_shot: got writes=%0d state=%0d expected 1 and 8",
        write_count - w0, db_estado_dispara);
    end
    disparar = 1'b0;
    // fresh shot, then a press while the cooldown is still running
    load_mem('0);
    wait_pronto(ok);
    disparar = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (disparo_concluido) break;
    end
    disparar = 1'b0;
    repeat (3) @(negedge clock);
    w0 = write_count;
    disparar = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (write_count !== w0 || db_estado_dispara !== 5'd1 || pronto !== 1'b0) begin
      failures++; $display("FAIL cooldown_ignore: got writes=%0d state=%0d pronto=%b expected 0/1/0",
        write_count - w0, db_estado_dispara, pronto);
    end
    disparar = 1'b0;
    wait_pronto(ok);
    k = first_free(slot_mem);
    run_shot();
    checks++;
    if (!ok || obs_writes !== 1 || obs_addr !== k) begin
      failures++; $display("FAIL cooldown_expired: got pronto=%b writes=%0d addr=%0d expected 1/1/%0d",
        ok, obs_writes, obs_addr, k);
    end
    $display("test_hold_cooldown addr=%0d", obs_addr);
  endtask

  task automatic test_move_ativo;
    bit ok, stuck;
    int w0, wcnt;
    load_mem('0);
    wait_pronto(ok);
    w0 = write_count;
    move_ativo = 1'b1;
    disparar = 1'b1;
    stuck = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (db_estado_dispara !== 5'd1) stuck = 1'b0;
    end
    checks++;
    if (!stuck || write_count !== w0) begin
      failures++; $display("FAIL move_blocks: got stayed=%b writes=%0d expected 1 and 0",
        stuck, write_count - w0);
    end
    move_ativo = 1'b0;
    wcnt = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (i == 1) move_ativo = 1'b1;
      if (mem_if.enable_mem_tiro && wcnt < 0) wcnt = i;
    end
    move_ativo = 1'b0;
    disparar = 1'b0;
    checks++;
    if (wcnt !== write_latency(0)) begin
      failures++; $display("FAIL move_release: got write@%0d expected %0d", wcnt, write_latency(0));
    end
    $display("test_move_ativo write@%0d", wcnt);
  endtask

  task automatic test_reset_midscan;
    bit ok, seen;
    int w0, k;
    load_mem(4'b0011);
    wait_pronto(ok);
    w0 = write_count;
    disparar = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (db_estado_dispara == 5'd4) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL midscan_reach: got no PROXIMO expected PROXIMO"); end
    reset = 1'b0;
    #1;
    checks++;
    if (db_estado_dispara !== 5'd0 || mem_if.enable_mem_tiro !== 1'b0 || pronto !== 1'b0 ||
        mem_if.endereco_tiro !== '0 || mem_if.new_x !== '0) begin
      failures++; $display("FAIL midscan_abort: got state=%0d en=%b pronto=%b addr=%0d expected 0/0/0/0",
        db_estado_dispara, mem_if.enable_mem_tiro, pronto, mem_if.endereco_tiro);
    end
    disparar = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (write_count !== w0) begin
      failures++; $display("FAIL midscan_nowrite: got writes=%0d expected 0", write_count - w0);
    end
    reset = 1'b1;
    nave_x = 8'd100; nave_y = 8'd255; nave_direcao = 2'b10;
    wait_pronto(ok);
    k = first_free(slot_mem);
    run_shot();
    checks++;
    if (obs_writes !== 1 || obs_addr !== k || obs_x !== 100 || obs_y !== 255) begin
      failures++; $display("FAIL midscan_recover: got n=%0d addr=%0d x=%0d y=%0d expected 1/%0d/100/255",
        obs_writes, obs_addr, obs_x, obs_y, k);
    end
    $display("test_reset_midscan addr=%0d", obs_addr);
  endtask

  task automatic test_random;
    bit ok;
    int k, x, y, d, ex, ey;
    logic [N_TIROS-1:0] m;
    for (int it = 0; it < 12; it++) begin
      m = N_TIROS'($urandom_range(0, (1 << N_TIROS) - 1));
      load_mem(m);
      case ($urandom_range(0, 3))
        0: x = 0;
        1: x = 255;
        default: x = int'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 3))
        0: y = 0;
        1: y = 255;
        default: y = int'($urandom_range(0, 255));
      endcase
      d = int'($urandom_range(0, 3));
      nave_x = COORD_W'(x); nave_y = COORD_W'(y); nave_direcao = 2'(d);
      wait_pronto(ok);
      k = first_free(m);
      spawn(x, y, d, ex, ey);
      run_shot();
      checks++;
      if (k >= 0) begin
        if (obs_writes !== 1 || obs_addr !== k || obs_x !== ex || obs_y !== ey || obs_op !== d ||
            obs_wcnt !== write_latency(k) || obs_done_cnt !== write_latency(k) + 1) begin
          failures++;
          $display("FAIL random_shot[%0d]: got n=%0d addr=%0d x=%0d y=%0d op=%0d w@%0d expected 1/%0d/%0d/%0d/%0d w@%0d",
            it, obs_writes, obs_addr, obs_x, obs_y, obs_op, obs_wcnt, k, ex, ey, d, write_latency(k));
        end
      end else begin
        if (obs_writes !== 0 || obs_sem_cnt !== 2 * N_TIROS + 1) begin
          failures++; $display("FAIL random_full[%0d]: got writes=%0d sem@%0d expected 0 and %0d",
            it, obs_writes, obs_sem_cnt, 2 * N_TIROS + 1);
        end
      end
      $display("test_random it=%0d mem=%b pos=(%0d,%0d) dir=%0d slot=%0d", it, m, x, y, d, k);
    end
  endtask

  initial begin
    test_reset();
    test_basic_shot();
    test_scan_clamp();
    test_all_busy();
    test_hold_cooldown();
    test_move_ativo();
    test_reset_midscan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
